// File: rtl/gcd_rr_sched.sv
// ---------------------------------------------------------------------------
// gcd_rr_sched
//   Shared iterative GCD service. N requesters compete for one subtractive
//   GCD engine through a round-robin arbiter. The engine performs one
//   subtraction per clock, and the result is returned with the owner's ID.
//
// Parameters
//   W   operand / result width in bits
//   N   number of requesters (2..8)
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset
//   i_req_valid  [N]    per-requester request valid
//   i_req_a      [N*W]  operand A, requester i in bits [i*W +: W]
//   i_req_b      [N*W]  operand B, same packing
//   o_req_ready  [N]    one-hot grant; request i taken on valid[i] & ready[i]
//   o_rsp_valid         result valid (held until i_rsp_ready)
//   i_rsp_ready         consumer accepts result
//   o_rsp_id     [IDW]  requester that owns the result
//   o_rsp_gcd    [W]    GCD result
//   o_busy              high whenever the engine is not idle
//   o_rsp_iter   [W]    subtraction-step count of the result
//                       (present only when GCD_ITER_CNT_EN is defined)
//
// Build option
//   GCD_ITER_CNT_EN  adds the step counter and the o_rsp_iter port.
// ---------------------------------------------------------------------------
module gcd_rr_sched #(
   parameter int W = 7,
   parameter int N = 4,
   localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [N-1:0]     i_req_valid,
   input  logic [N*W-1:0]   i_req_a,
   input  logic [N*W-1:0]   i_req_b,
   output logic [N-1:0]     o_req_ready,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic [IDW-1:0]   o_rsp_id,
   output logic [W-1:0]     o_rsp_gcd,
   output logic             o_busy
`ifdef GCD_ITER_CNT_EN
   ,
   output logic [W-1:0]     o_rsp_iter
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

   localparam logic [IDW:0] N_EXT = (IDW+1)'(N);

   state_t           r_state;
   state_t           w_next;
   logic [IDW-1:0]   r_ptr;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic [IDW-1:0]   r_id;
   logic [W-1:0]     r_gcd;

   logic [N-1:0]     w_rot;
   logic             w_found;
   logic [IDW:0]     w_off;
   logic [IDW:0]     w_sum;
   logic [IDW-1:0]   w_win;
   logic [IDW-1:0]   w_ptr_nxt;
   logic [W-1:0]     w_sel_a;
   logic [W-1:0]     w_sel_b;
   logic             w_accept;
   logic             w_calc_end;

   // Rotate the valid vector so bit 0 is the requester at the pointer; the
   // first set bit of the rotated vector is then the round-robin winner.
   assign w_rot = N'({i_req_valid, i_req_valid} >> r_ptr);

   always_comb begin
      w_found = 1'b0;
      w_off   = '0;
      for (int k = 0; k < N; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_off   = (IDW+1)'(k);
         end
      end
      w_sum = {1'b0, r_ptr} + w_off;
      w_win = IDW'((w_sum >= N_EXT) ? (w_sum - N_EXT) : w_sum);
   end

   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int k = 0; k < N; k++) begin
         if (w_win == IDW'(k)) begin
            w_sel_a = i_req_a[k*W +: W];
            w_sel_b = i_req_b[k*W +: W];
         end
      end
   end

   assign w_ptr_nxt  = (w_win == IDW'(N-1)) ? '0 : w_win + 1'b1;
   assign w_accept   = (r_state == ST_IDLE) && w_found;
   // Zero, equal, or either operand zero all terminate; gcd(0,0) falls out as 0.
   assign w_calc_end = (r_a == '0) || (r_b == '0) || (r_a == r_b);

   // Grant is gated by reset so no requester sees ready while the block is held.
   assign o_req_ready = (w_accept && i_rst_n) ? (N'(1) << w_win) : '0;
   assign o_rsp_valid = (r_state == ST_DONE);
   assign o_busy      = (r_state != ST_IDLE);
   assign o_rsp_id    = r_id;
   assign o_rsp_gcd   = r_gcd;

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)    w_next = ST_CALC;
         ST_CALC: if (w_calc_end)  w_next = ST_DONE;
         ST_DONE: if (i_rsp_ready) w_next = ST_IDLE;
         default:                  w_next = ST_IDLE;
      endcase
   end

   // Datapath: operand latch, one subtraction per CALC cycle, result hold
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ptr <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_id  <= '0;
         r_gcd <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a   <= w_sel_a;
                  r_b   <= w_sel_b;
                  r_id  <= w_win;
                  r_ptr <= w_ptr_nxt;
               end
            end
            ST_CALC: begin
               if (r_a == '0)                        r_gcd <= r_b;
               else if ((r_b == '0) || (r_a == r_b)) r_gcd <= r_a;
               else if (r_a < r_b)                   r_b   <= r_b - r_a;
               else                                  r_a   <= r_a - r_b;
            end
            default: ;
         endcase
      end
   end

`ifdef GCD_ITER_CNT_EN
   logic [W-1:0] r_iter;

   // Counts subtraction steps only; terminating cycles do not count.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)                          r_iter <= '0;
      else if (w_accept)                     r_iter <= '0;
      else if ((r_state == ST_CALC) && !w_calc_end) r_iter <= r_iter + 1'b1;
   end

   assign o_rsp_iter = r_iter;
`endif

endmodule

// File: tb/tb_gcd_rr_sched.sv
module tb_gcd_rr_sched;
   localparam int W   = 7;
   localparam int N   = 4;
   localparam int IDW = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   logic [N*W-1:0]   req_a;
   logic [N*W-1:0]   req_b;
   logic [N-1:0]     req_ready;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [IDW-1:0]   rsp_id;
   logic [W-1:0]     rsp_gcd;
   logic             busy;
`ifdef GCD_ITER_CNT_EN
   logic [W-1:0]     rsp_iter;
`endif

   gcd_rr_sched #(.W(W), .N(N)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .i_req_a     (req_a),
      .i_req_b     (req_b),
      .o_req_ready (req_ready),
      .o_rsp_valid (rsp_valid),
      .i_rsp_ready (rsp_ready),
      .o_rsp_id    (rsp_id),
      .o_rsp_gcd   (rsp_gcd),
      .o_busy      (busy)
`ifdef GCD_ITER_CNT_EN
      ,
      .o_rsp_iter  (rsp_iter)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int gcd;
      int lat;
      int acc_cyc;
   } exp_t;

   exp_t         sb[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           acc_cnt = 0;
   int           hs_cnt = 0;
   int           discarded = 0;
   int           rise_cyc = 0;
   logic         prev_v = 1'b0;
   logic [N-1:0] last_acc = '0;
   int           exp_gcd [N];
   int           exp_lat [N];
   int           wait_cnt [N];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int got, input int exp_v);
      checks++;
      if (got != exp_v) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", nm, got, exp_v, $time);
      end
   endtask

   function automatic int gcd_model(input int a, input int b);
      int x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int i, input int a, input int b, input int g, input int lat);
      req_a[i*W +: W] = W'(a);
      req_b[i*W +: W] = W'(b);
      exp_gcd[i]      = g;
      exp_lat[i]      = lat;
      req_valid[i]    = 1'b1;
   endtask

   task automatic wait_accept(input int i);
      for (int t = 0; t < 400; t++) begin
         step();
         if (last_acc[i]) begin
            req_valid[i] = 1'b0;
            return;
         end
      end
      chk("accept_timeout", 0, 1);
   endtask

   task automatic wait_any_accept(output int idx);
      idx = -1;
      for (int t = 0; t < 400; t++) begin
         step();
         if (last_acc != '0) begin
            for (int j = N-1; j >= 0; j--) if (last_acc[j]) idx = j;
            req_valid[idx] = 1'b0;
            return;
         end
      end
      chk("any_accept_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) return;
      end
      chk("drain_timeout", 0, 1);
   endtask

   // Accept monitor: records expectations and checks grant shape / fairness
   initial begin : mon_acc
      forever begin
         @(negedge clk);
         last_acc = req_valid & req_ready;
         if (last_acc != '0) begin
            chk("grant_onehot", $countones(req_ready), 1);
            for (int j = 0; j < N; j++) begin
               if (last_acc[j]) begin
                  sb.push_back('{j, exp_gcd[j], exp_lat[j], cyc});
                  acc_cnt++;
                  wait_cnt[j] = 0;
               end else if (req_valid[j]) begin
                  wait_cnt[j]++;
                  if (wait_cnt[j] > N-1) chk("starve", wait_cnt[j], N-1);
               end else begin
                  wait_cnt[j] = 0;
               end
            end
         end
      end
   end

   // Response monitor: pops the scoreboard on every handshake
   initial begin : mon_rsp
      exp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid && !prev_v) rise_cyc = cyc;
         prev_v = rsp_valid;
         if (rsp_valid && rsp_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected got id=%0d gcd=%0d exp none", rsp_id, rsp_gcd);
            end else begin
               e = sb.pop_front();
               chk("rsp_id", int'(rsp_id), e.id);
               chk("rsp_gcd", int'(rsp_gcd), e.gcd);
               if (e.lat >= 0) begin
                  chk("rsp_latency", rise_cyc - e.acc_cyc, e.lat);
`ifdef GCD_ITER_CNT_EN
                  chk("rsp_iter", int'(rsp_iter), e.lat - 2);
`endif
               end
            end
         end
      end
   end

   int edge_a   [5] = '{0, 9, 0, 7, 127};
   int edge_b   [5] = '{9, 0, 0, 7, 1};
   int edge_g   [5] = '{9, 9, 0, 7, 1};
   int edge_lat [5] = '{2, 2, 2, 2, 128};
   int rr_order [5] = '{0, 1, 2, 3, 0};

   initial begin : driver
      int idx;
      int issued;
      int a, b;
      bit done_soak;
      for (int j = 0; j < N; j++) begin
         exp_gcd[j] = 0;
         exp_lat[j] = -1;
         wait_cnt[j] = 0;
      end
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req_a     = '0;
      req_b     = '0;
      req_valid = '1;

      // Reset state, with requests pending to show ready stays low
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_gcd", rsp_gcd, 0);
      step();
      req_valid = '0;
      rst_n = 1'b1;

      // Single request from requester 2
      step();
      issue(2, 12, 8, 4, 4);
      @(negedge clk);
      chk("t1_ready_onehot", req_ready, 4'b0100);
      wait_accept(2);
      @(negedge clk);
      chk("t1_ready_after", req_ready, 0);
      chk("t1_busy", busy, 1);
      drain();

      // Edge operands
      for (int n = 0; n < 5; n++) begin
         step();
         issue(0, edge_a[n], edge_b[n], edge_g[n], edge_lat[n]);
         wait_accept(0);
         drain();
      end

      // Backpressure: job on 1 stalls in DONE while 3 waits
      step();
      rsp_ready = 1'b0;
      issue(1, 9, 6, 3, 4);
      wait_accept(1);
      issue(3, 20, 8, 4, -1);
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      for (int n = 0; n < 10; n++) begin
         chk("bp_valid", rsp_valid, 1);
         chk("bp_id", rsp_id, 1);
         chk("bp_gcd", rsp_gcd, 3);
         chk("bp_ready", req_ready, 0);
         chk("bp_busy", busy, 1);
         @(negedge clk);
      end
      step();
      rsp_ready = 1'b1;
      wait_accept(3);
      drain();

      // All requesters valid: round-robin order 0,1,2,3,0
      step();
      issue(0, 12, 18, 6, -1);
      issue(1, 35, 21, 7, -1);
      issue(2, 17, 5, 1, -1);
      issue(3, 64, 48, 16, -1);
      for (int n = 0; n < 5; n++) begin
         wait_any_accept(idx);
         chk("rr_order", idx, rr_order[n]);
         if (n == 0) issue(0, 100, 75, 25, -1);
      end
      drain();

      // Reset during CALC discards the job and clears the pointer
      step();
      issue(2, 126, 1, 1, -1);
      wait_accept(2);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      issue(0, 45, 30, 15, 4);
      issue(3, 14, 21, 7, 4);
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_gcd", rsp_gcd, 0);
      sb.delete();
      discarded++;
      for (int j = 0; j < N; j++) wait_cnt[j] = 0;
      step();
      rst_n = 1'b1;
      wait_any_accept(idx);
      chk("post_rst_ptr0", idx, 0);
      wait_any_accept(idx);
      chk("post_rst_next", idx, 3);
      drain();

      // Random soak with random response backpressure
      issued = 0;
      done_soak = 1'b0;
      step();
      for (int t = 0; t < 60000; t++) begin
         for (int j = 0; j < N; j++) if (last_acc[j]) req_valid[j] = 1'b0;
         if (issued >= 400 && req_valid == '0) begin
            done_soak = 1'b1;
            break;
         end
         for (int j = 0; j < N; j++) begin
            if (!req_valid[j] && issued < 400 && $urandom_range(0, 2) == 0) begin
               a = int'($urandom_range(0, 127));
               b = int'($urandom_range(0, 127));
               issue(j, a, b, gcd_model(a, b), -1);
               issued++;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      if (!done_soak) chk("soak_timeout", 0, 1);
      rsp_ready = 1'b1;
      drain();

      chk("handshake_count", hs_cnt, acc_cnt - discarded);
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
